// File: rtl/mi3_pkg.sv
// Shared definitions for the mi3 vector issue stage.
package mi3_pkg;

   localparam int unsigned REG_AW_DFLT = 5;
   localparam int unsigned NUM_REGS    = 1 << REG_AW_DFLT;

   // Issue slot index, in program order
   typedef enum logic [1:0] {
      SLOT_IS1 = 2'd0,
      SLOT_IS2 = 2'd1,
      SLOT_IS3 = 2'd2
   } slot_e;

endpackage

// File: rtl/mi3_issue_ctrl_if.sv
// Issue-slot handshake and writeback bus between dispatch and the issue controller.
interface mi3_issue_ctrl_if #(
   parameter int unsigned REG_AW = mi3_pkg::REG_AW_DFLT
) ();

   logic              is1_valid_i, is2_valid_i, is3_valid_i;
   logic              is1_ready_o, is2_ready_o, is3_ready_o;

   logic              is1_rs1_en_i, is1_rs2_en_i;
   logic              is2_rs1_en_i, is2_rs2_en_i;
   logic              is3_rs1_en_i;
   logic [REG_AW-1:0] is1_rs1_addr_i, is1_rs2_addr_i;
   logic [REG_AW-1:0] is2_rs1_addr_i, is2_rs2_addr_i;
   logic [REG_AW-1:0] is3_rs1_addr_i;

   logic              is1_rd_en_i, is2_rd_en_i;
   logic [REG_AW-1:0] is1_rd_addr_i, is2_rd_addr_i;

   logic              wb1_en_i, wb2_en_i;
   logic [REG_AW-1:0] wb1_addr_i, wb2_addr_i;

   // Dispatch side: presents instructions and writebacks, receives grants
   modport master (
      output is1_valid_i, is2_valid_i, is3_valid_i,
      output is1_rs1_en_i, is1_rs2_en_i, is2_rs1_en_i, is2_rs2_en_i, is3_rs1_en_i,
      output is1_rs1_addr_i, is1_rs2_addr_i, is2_rs1_addr_i, is2_rs2_addr_i, is3_rs1_addr_i,
      output is1_rd_en_i, is2_rd_en_i, is1_rd_addr_i, is2_rd_addr_i,
      output wb1_en_i, wb2_en_i, wb1_addr_i, wb2_addr_i,
      input  is1_ready_o, is2_ready_o, is3_ready_o
   );

   // Issue controller side
   modport slave (
      input  is1_valid_i, is2_valid_i, is3_valid_i,
      input  is1_rs1_en_i, is1_rs2_en_i, is2_rs1_en_i, is2_rs2_en_i, is3_rs1_en_i,
      input  is1_rs1_addr_i, is1_rs2_addr_i, is2_rs1_addr_i, is2_rs2_addr_i, is3_rs1_addr_i,
      input  is1_rd_en_i, is2_rd_en_i, is1_rd_addr_i, is2_rd_addr_i,
      input  wb1_en_i, wb2_en_i, wb1_addr_i, wb2_addr_i,
      output is1_ready_o, is2_ready_o, is3_ready_o
   );

endinterface

// File: rtl/mi3_busy_table.sv
// Per-register busy bitmap: two set ports, two clear ports, flush; set beats clear.
module mi3_busy_table #(
   parameter int unsigned REG_AW = mi3_pkg::REG_AW_DFLT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic [1:0]                   set_en_i,
   input  logic [1:0][REG_AW-1:0]       set_addr_i,
   input  logic [1:0]                   clr_en_i,
   input  logic [1:0][REG_AW-1:0]       clr_addr_i,
   output logic [(1 << REG_AW)-1:0]     busy_o
);

   localparam int unsigned NREG = 1 << REG_AW;

   logic [NREG-1:0] busy_q, busy_d;
   logic [NREG-1:0] set_mask, clr_mask;

   // Decode set/clear ports to masks and form the next bitmap
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int p = 0; p < 2; p++) begin
         if (set_en_i[p]) set_mask = set_mask | (NREG'(1) << set_addr_i[p]);
         if (clr_en_i[p]) clr_mask = clr_mask | (NREG'(1) << clr_addr_i[p]);
      end
      if (flush_i) busy_d = '0;
      else         busy_d = (busy_q & ~clr_mask) | set_mask;
   end

   // Bitmap register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/mi3_issue_ctrl.sv
// In-order three-slot issue controller: hazard compare, grant chain, stall counter.
module mi3_issue_ctrl
   import mi3_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DFLT,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   mi3_issue_ctrl_if.slave          bus,
   input  logic                     flush_i,
   output logic [(1 << REG_AW)-1:0] busy_o,
   output logic [CNT_W-1:0]         stall_cnt_o
);

   localparam int unsigned NREG = 1 << REG_AW;

   logic [NREG-1:0]  busy_q;
   logic             haz1, haz2, haz3;
   logic             dep12, dep3;
   logic [2:0]       rdy;
   logic             go1, go2;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Scoreboard hazards against the registered bitmap (no writeback bypass)
   always_comb begin
      haz1 = (bus.is1_rs1_en_i & busy_q[bus.is1_rs1_addr_i])
           | (bus.is1_rs2_en_i & busy_q[bus.is1_rs2_addr_i])
           | (bus.is1_rd_en_i  & busy_q[bus.is1_rd_addr_i]);
      haz2 = (bus.is2_rs1_en_i & busy_q[bus.is2_rs1_addr_i])
           | (bus.is2_rs2_en_i & busy_q[bus.is2_rs2_addr_i])
           | (bus.is2_rd_en_i  & busy_q[bus.is2_rd_addr_i]);
      haz3 = bus.is3_rs1_en_i & busy_q[bus.is3_rs1_addr_i];
   end

   // Grant chain: older slots must issue (or be empty) for a younger one to go
   always_comb begin
      rdy = '0;

      rdy[SLOT_IS1] = ~flush_i & ~haz1;
      go1           = bus.is1_valid_i & rdy[SLOT_IS1];

      dep12 = go1 & bus.is1_rd_en_i &
              ((bus.is2_rs1_en_i & (bus.is1_rd_addr_i == bus.is2_rs1_addr_i)) |
               (bus.is2_rs2_en_i & (bus.is1_rd_addr_i == bus.is2_rs2_addr_i)) |
               (bus.is2_rd_en_i  & (bus.is1_rd_addr_i == bus.is2_rd_addr_i)));
      rdy[SLOT_IS2] = ~flush_i & ~haz2 & ~dep12 & (go1 | ~bus.is1_valid_i);
      go2           = bus.is2_valid_i & rdy[SLOT_IS2];

      dep3 = bus.is3_rs1_en_i &
             ((go1 & bus.is1_rd_en_i & (bus.is1_rd_addr_i == bus.is3_rs1_addr_i)) |
              (go2 & bus.is2_rd_en_i & (bus.is2_rd_addr_i == bus.is3_rs1_addr_i)));
      rdy[SLOT_IS3] = ~flush_i & ~haz3 & ~dep3 & (go2 | ~bus.is2_valid_i) &
                      (go1 | ~bus.is1_valid_i);
   end

   assign bus.is1_ready_o = rdy[SLOT_IS1];
   assign bus.is2_ready_o = rdy[SLOT_IS2];
   assign bus.is3_ready_o = rdy[SLOT_IS3];

   // Busy bitmap: issuing destinations set, writebacks clear
   mi3_busy_table #(.REG_AW(REG_AW)) u_busy (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_i),
      .set_en_i   ({go2 & bus.is2_rd_en_i, go1 & bus.is1_rd_en_i}),
      .set_addr_i ({bus.is2_rd_addr_i, bus.is1_rd_addr_i}),
      .clr_en_i   ({bus.wb2_en_i, bus.wb1_en_i}),
      .clr_addr_i ({bus.wb2_addr_i, bus.wb1_addr_i}),
      .busy_o     (busy_q)
   );

   assign busy_o = busy_q;

   // Saturating count of cycles where the oldest slot is held
   always_comb begin
      cnt_d = cnt_q;
      if (bus.is1_valid_i && !rdy[SLOT_IS1] && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Stall counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_mi3_issue_ctrl.sv
// Directed vector bench for mi3_issue_ctrl (REG_AW=5, CNT_W=4).
module tb_mi3_issue_ctrl;
   import mi3_pkg::*;

   localparam int unsigned AW  = 5;
   localparam int unsigned CW  = 4;
   localparam int unsigned NV  = 18;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush;
   logic [31:0]    busy;
   logic [CW-1:0]  cnt;

   int n_checks = 0;
   int n_errors = 0;

   mi3_issue_ctrl_if #(.REG_AW(AW)) bus ();

   mi3_issue_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .flush_i     (flush),
      .busy_o      (busy),
      .stall_cnt_o (cnt)
   );

   always #5 clk = ~clk;

   // e* fields are {rd_en, rs2_en, rs1_en}; v/rdy bit0 = is1
   typedef struct {
      logic [2:0]  v;
      logic [2:0]  e1;
      logic [4:0]  a1s1, a1s2, a1d;
      logic [2:0]  e2;
      logic [4:0]  a2s1, a2s2, a2d;
      logic        e3;
      logic [4:0]  a3s1;
      logic [1:0]  wbe;
      logic [4:0]  wba1, wba2;
      logic        fl;
      logic [2:0]  rdy;
      logic [31:0] xbusy;
      logic [3:0]  xcnt;
   } vec_t;

   vec_t vec [NV];

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      bus.is1_valid_i    = t.v[0];
      bus.is2_valid_i    = t.v[1];
      bus.is3_valid_i    = t.v[2];
      bus.is1_rs1_en_i   = t.e1[0];
      bus.is1_rs2_en_i   = t.e1[1];
      bus.is1_rd_en_i    = t.e1[2];
      bus.is1_rs1_addr_i = t.a1s1;
      bus.is1_rs2_addr_i = t.a1s2;
      bus.is1_rd_addr_i  = t.a1d;
      bus.is2_rs1_en_i   = t.e2[0];
      bus.is2_rs2_en_i   = t.e2[1];
      bus.is2_rd_en_i    = t.e2[2];
      bus.is2_rs1_addr_i = t.a2s1;
      bus.is2_rs2_addr_i = t.a2s2;
      bus.is2_rd_addr_i  = t.a2d;
      bus.is3_rs1_en_i   = t.e3;
      bus.is3_rs1_addr_i = t.a3s1;
      bus.wb1_en_i       = t.wbe[0];
      bus.wb2_en_i       = t.wbe[1];
      bus.wb1_addr_i     = t.wba1;
      bus.wb2_addr_i     = t.wba2;
      flush              = t.fl;
   endtask

   function automatic logic [31:0] rdy_now();
      return {29'd0, bus.is3_ready_o, bus.is2_ready_o, bus.is1_ready_o};
   endfunction

   vec_t idle;

   initial begin
      //          v       e1    a1s1  a1s2  a1d    e2    a2s1  a2s2  a2d    e3  a3    wbe   wb1    wb2    fl  rdy     busy          cnt
      vec[0]  = '{3'b111, 3'b100, 5'd0, 5'd0, 5'd3,  3'b100, 5'd0, 5'd0, 5'd4,  1, 5'd5,  2'b00, 5'd0,  5'd0,  0, 3'b111, 32'h0000_0018, 4'd0};
      vec[1]  = '{3'b001, 3'b100, 5'd0, 5'd0, 5'd7,  3'b000, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b00, 5'd0,  5'd0,  0, 3'b111, 32'h0000_0098, 4'd0};
      vec[2]  = '{3'b010, 3'b000, 5'd0, 5'd0, 5'd0,  3'b001, 5'd7, 5'd0, 5'd0,  0, 5'd0,  2'b00, 5'd0,  5'd0,  0, 3'b001, 32'h0000_0098, 4'd0};
      vec[3]  = '{3'b010, 3'b000, 5'd0, 5'd0, 5'd0,  3'b001, 5'd7, 5'd0, 5'd0,  0, 5'd0,  2'b01, 5'd7,  5'd0,  0, 3'b001, 32'h0000_0018, 4'd0};
      vec[4]  = '{3'b010, 3'b000, 5'd0, 5'd0, 5'd0,  3'b001, 5'd7, 5'd0, 5'd0,  0, 5'd0,  2'b00, 5'd0,  5'd0,  0, 3'b111, 32'h0000_0018, 4'd0};
      vec[5]  = '{3'b111, 3'b100, 5'd0, 5'd0, 5'd9,  3'b010, 5'd0, 5'd9, 5'd0,  1, 5'd1,  2'b00, 5'd0,  5'd0,  0, 3'b001, 32'h0000_0218, 4'd0};
      vec[6]  = '{3'b000, 3'b000, 5'd0, 5'd0, 5'd0,  3'b000, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b11, 5'd9,  5'd3,  0, 3'b111, 32'h0000_0010, 4'd0};
      vec[7]  = '{3'b001, 3'b100, 5'd0, 5'd0, 5'd6,  3'b000, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b11, 5'd6,  5'd4,  0, 3'b111, 32'h0000_0040, 4'd0};
      vec[8]  = '{3'b001, 3'b100, 5'd0, 5'd0, 5'd6,  3'b000, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b00, 5'd0,  5'd0,  0, 3'b000, 32'h0000_0040, 4'd1};
      vec[9]  = '{3'b000, 3'b000, 5'd0, 5'd0, 5'd0,  3'b000, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b11, 5'd6,  5'd6,  0, 3'b111, 32'h0000_0000, 4'd1};
      vec[10] = '{3'b011, 3'b100, 5'd0, 5'd0, 5'd4,  3'b100, 5'd0, 5'd0, 5'd5,  0, 5'd0,  2'b00, 5'd0,  5'd0,  0, 3'b111, 32'h0000_0030, 4'd1};
      vec[11] = '{3'b011, 3'b100, 5'd0, 5'd0, 5'd6,  3'b100, 5'd0, 5'd0, 5'd7,  0, 5'd0,  2'b00, 5'd0,  5'd0,  0, 3'b111, 32'h0000_00F0, 4'd1};
      vec[12] = '{3'b111, 3'b100, 5'd0, 5'd0, 5'd8,  3'b100, 5'd0, 5'd0, 5'd9,  1, 5'd2,  2'b00, 5'd0,  5'd0,  1, 3'b000, 32'h0000_0000, 4'd2};
      vec[13] = '{3'b000, 3'b000, 5'd0, 5'd0, 5'd0,  3'b000, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b01, 5'd5,  5'd0,  0, 3'b111, 32'h0000_0000, 4'd2};
      vec[14] = '{3'b111, 3'b100, 5'd0, 5'd0, 5'd10, 3'b100, 5'd0, 5'd0, 5'd11, 1, 5'd11, 2'b00, 5'd0,  5'd0,  0, 3'b011, 32'h0000_0C00, 4'd2};
      vec[15] = '{3'b100, 3'b000, 5'd0, 5'd0, 5'd0,  3'b000, 5'd0, 5'd0, 5'd0,  1, 5'd10, 2'b00, 5'd0,  5'd0,  0, 3'b011, 32'h0000_0C00, 4'd2};
      vec[16] = '{3'b001, 3'b100, 5'd0, 5'd0, 5'd0,  3'b000, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b11, 5'd10, 5'd11, 0, 3'b111, 32'h0000_0001, 4'd2};
      vec[17] = '{3'b010, 3'b000, 5'd0, 5'd0, 5'd0,  3'b001, 5'd0, 5'd0, 5'd0,  0, 5'd0,  2'b00, 5'd0,  5'd0,  0, 3'b001, 32'h0000_0001, 4'd2};

      idle = '{3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 5'd0,
               2'b00, 5'd0, 5'd0, 0, 3'b000, 32'h0, 4'd0};

      // Asynchronous reset: state clear before any clock edge
      drive(idle);
      rst = 1'b0;
      #1;
      check("reset_busy", 0, busy, 32'h0);
      check("reset_cnt", 0, 32'(cnt), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Cycle-by-cycle vector table
      for (int i = 0; i < int'(NV); i++) begin
         @(negedge clk);
         drive(vec[i]);
         #1;
         check("ready", i, rdy_now(), 32'(vec[i].rdy));
         @(posedge clk);
         #1;
         check("busy", i, busy, vec[i].xbusy);
         check("stall_cnt", i, 32'(cnt), 32'(vec[i].xcnt));
      end

      // Saturation: is1 blocked on busy r0 (stall count currently 2)
      @(negedge clk);
      drive(idle);
      bus.is1_valid_i = 1'b1;
      bus.is1_rd_en_i = 1'b1;
      bus.is1_rd_addr_i = 5'd0;
      for (int c = 0; c < (1 << CW) + 3; c++) begin
         @(posedge clk);
         #1;
         if (c == 11) check("stall_cnt_mid", c, 32'(cnt), 32'd14);
         if (c == 12) check("stall_cnt_sat", c, 32'(cnt), 32'd15);
      end
      check("stall_cnt_hold", 0, 32'(cnt), 32'd15);
      check("is1_blocked", 0, rdy_now(), 32'b000);

      // Asynchronous reset pulse mid-cycle, away from any edge
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_busy", 0, busy, 32'h0);
      check("midrst_cnt", 0, 32'(cnt), 32'h0);
      check("midrst_ready", 0, rdy_now(), 32'b111);
      @(negedge clk);
      rst = 1'b1;

      // Stale writeback after reset is a no-op; is1 issues r0
      drive(idle);
      bus.is1_valid_i = 1'b1;
      bus.is1_rd_en_i = 1'b1;
      bus.is1_rd_addr_i = 5'd0;
      bus.wb1_en_i = 1'b1;
      bus.wb1_addr_i = 5'd3;
      #1;
      check("postrst_ready", 0, rdy_now(), 32'b111);
      @(posedge clk);
      #1;
      check("postrst_busy", 0, busy, 32'h0000_0001);
      check("postrst_cnt", 0, 32'(cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
